// File: rtl/data_bus_timer.sv
// data_bus_timer: memory-mapped 64-bit machine timer with prescaler, HI read shadow
// and registered level interrupt on a single-cycle data bus.
module data_bus_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] data_bus_addr,
   input  logic [1:0]  data_bus_mode,
   inout  wire  [31:0] data_bus_data,
   output logic        timer_irq
);
   logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
   logic [31:0] shadow_q, shadow_d, rdata;
   logic [7:0]  pre_q, pre_d, pcnt_q, pcnt_d;
   logic        en_q, en_d, irq_q, irq_d;
   logic        sel, rd, wr, tick;
   logic [2:0]  off;

   always_comb begin
      sel = data_bus_addr[31:5] == BASE_ADDR[31:5] && data_bus_addr[1:0] == 2'b00;
      rd = sel && data_bus_mode == 2'b01 && reset_n;
      wr = sel && data_bus_mode == 2'b10;
      off = data_bus_addr[4:2];
      tick = en_q && pcnt_q == pre_q;
      rdata = off == 3'd0 ? mtime_q[31:0] :
              off == 3'd1 ? shadow_q :
              off == 3'd2 ? cmp_q[31:0] :
              off == 3'd3 ? cmp_q[63:32] :
              off == 3'd4 ? {16'd0, pre_q, 7'd0, en_q} : 32'd0;
      // a word write wins over a same-cycle tick, with no carry into the other word
      mtime_d = wr && off == 3'd0 ? {mtime_q[63:32], data_bus_data} :
                wr && off == 3'd1 ? {data_bus_data, mtime_q[31:0]} :
                mtime_q + {63'd0, tick};
      cmp_d = wr && off == 3'd2 ? {cmp_q[63:32], data_bus_data} :
              wr && off == 3'd3 ? {data_bus_data, cmp_q[31:0]} : cmp_q;
      en_d = wr && off == 3'd4 ? data_bus_data[0] : en_q;
      pre_d = wr && off == 3'd4 ? data_bus_data[15:8] : pre_q;
      pcnt_d = (wr && off == 3'd4) || !en_q || tick ? 8'd0 : pcnt_q + 8'd1;
      shadow_d = rd && off == 3'd0 ? mtime_q[63:32] : shadow_q;
      irq_d = en_q && mtime_q >= cmp_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mtime_q <= 64'd0;
         cmp_q <= '1;
         shadow_q <= 32'd0;
         en_q <= 1'b0;
         pre_q <= 8'd0;
         pcnt_q <= 8'd0;
         irq_q <= 1'b0;
      end else begin
         mtime_q <= mtime_d;
         cmp_q <= cmp_d;
         shadow_q <= shadow_d;
         en_q <= en_d;
         pre_q <= pre_d;
         pcnt_q <= pcnt_d;
         irq_q <= irq_d;
      end
   end

   assign data_bus_data = rd ? rdata : 32'bz;
   assign timer_irq = irq_q;
endmodule

// File: tb/tb_data_bus_timer.sv
// tb_data_bus_timer: scoreboarded random + directed bench for data_bus_timer against
// a cycle-level behavioural model of the register map and timer.
module tb_data_bus_timer;
   localparam logic [31:0] BASE = 32'h0000_2000;
   logic        clk = 1'b0, reset_n = 1'b0, timer_irq;
   logic [31:0] addr = '0, wdata = '0;
   logic [1:0]  mode = '0;
   wire  [31:0] bus;

   assign bus = (mode == 2'b10) ? wdata : 32'bz;
   always #5 clk = ~clk;

   data_bus_timer #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset_n(reset_n), .data_bus_addr(addr),
      .data_bus_mode(mode), .data_bus_data(bus), .timer_irq(timer_irq)
   );

   typedef struct { logic [31:0] bus; logic irq; int cyc; } exp_t;
   exp_t q[$];
   exp_t me;
   int tests = 0, fails = 0, ncyc = 0;

   logic [63:0] m_time, m_cmp;
   logic [31:0] m_sh;
   logic [7:0]  m_pre;
   logic        m_en, m_irq;
   int          m_el;
   logic        p_rst = 1'b0;
   logic [1:0]  p_mode = '0;
   logic [31:0] p_addr = '0, p_data = '0;

   function automatic logic hit(input logic [31:0] a);
      return a[31:5] == BASE[31:5] && a[1:0] == 2'b00;
   endfunction

   function automatic logic [31:0] m_reg(input logic [2:0] o);
      case (o)
         3'd0: return m_time[31:0];
         3'd1: return m_sh;
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return {16'd0, m_pre, 7'd0, m_en};
         default: return 32'd0;
      endcase
   endfunction

   // apply the effect of the rising edge that ended the previous bus cycle
   task automatic model_edge();
      logic [2:0] o;
      logic w, r, nirq, tk;
      o = p_addr[4:2];
      w = hit(p_addr) && p_mode == 2'b10;
      r = hit(p_addr) && p_mode == 2'b01;
      if (!p_rst) begin
         m_time = '0; m_cmp = '1; m_sh = '0; m_en = 0; m_pre = '0; m_el = 0; m_irq = 0;
      end else begin
         nirq = m_en && (m_time >= m_cmp);
         tk = m_en && (m_el % (int'(m_pre) + 1)) == int'(m_pre);
         m_el = m_en ? m_el + 1 : 0;
         if (r && o == 3'd0) m_sh = m_time[63:32];
         if (w && o == 3'd0) m_time[31:0] = p_data;
         else if (w && o == 3'd1) m_time[63:32] = p_data;
         else if (tk) m_time = m_time + 64'd1;
         if (w && o == 3'd2) m_cmp[31:0] = p_data;
         if (w && o == 3'd3) m_cmp[63:32] = p_data;
         if (w && o == 3'd4) begin
            m_en = p_data[0]; m_pre = p_data[15:8]; m_el = 0;
         end
         m_irq = nirq;
      end
   endtask

   task automatic cyc(input logic r, input logic [1:0] m, input logic [31:0] a, input logic [31:0] d,
                      input logic k, input logic [31:0] kv);
      exp_t e;
      @(posedge clk);
      #1;
      model_edge();
      reset_n = r; mode = m; addr = a; wdata = d;
      p_rst = r; p_mode = m; p_addr = a; p_data = d;
      e.bus = (m == 2'b10) ? d : (r && m == 2'b01 && hit(a)) ? (k ? kv : m_reg(a[4:2])) : 32'bz;
      e.irq = m_irq;
      e.cyc = ncyc++;
      q.push_back(e);
   endtask

   task automatic rd(input logic [31:0] a);  cyc(1, 2'b01, a, 0, 0, 0); endtask
   task automatic rdk(input logic [31:0] a, input logic [31:0] v); cyc(1, 2'b01, a, 0, 1, v); endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d); cyc(1, 2'b10, a, d, 0, 0); endtask
   task automatic idle(input int n); repeat (n) cyc(1, 2'b00, 0, 0, 0, 0); endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         me = q.pop_front();
         tests += 2;
         if (bus !== me.bus) begin
            fails++;
            $display("FAIL bus cyc=%0d got=%h exp=%h", me.cyc, bus, me.bus);
         end
         if (timer_irq !== me.irq) begin
            fails++;
            $display("FAIL irq cyc=%0d got=%b exp=%b", me.cyc, timer_irq, me.irq);
         end
      end
   end

   initial begin
      logic [31:0] init_v [8];
      logic [31:0] a, d;
      logic [2:0]  o;
      init_v = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
      cyc(0, 2'b01, BASE, 0, 0, 0);
      cyc(0, 2'b00, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) rdk(BASE + 32'(i * 4), init_v[i]);
      idle(1);
      wr(BASE + 32'h10, 32'h0000_0301);
      idle(20);
      rdk(BASE, 32'd5);
      for (int i = 0; i < 12; i++) rd(BASE);
      wr(BASE + 32'h10, 0);
      wr(BASE, 32'hFFFF_FFFE);
      wr(BASE + 32'h4, 0);
      wr(BASE + 32'h10, 1);
      idle(3);
      rdk(BASE, 32'd1);
      rdk(BASE + 32'h4, 32'd1);
      wr(BASE + 32'h4, 32'h55);
      rdk(BASE + 32'h4, 32'd1);
      wr(BASE + 32'h10, 0);
      wr(BASE + 32'hC, 0);
      wr(BASE + 32'h8, 10);
      wr(BASE, 0);
      wr(BASE + 32'h4, 0);
      wr(BASE + 32'h10, 1);
      idle(14);
      wr(BASE + 32'h8, 100);
      idle(3);
      wr(BASE + 32'h8, 0);
      idle(3);
      wr(BASE + 32'h10, 0);
      idle(3);
      wr(BASE + 32'h2, 32'hDEAD_BEEF);
      rd(BASE + 32'h2);
      wr(BASE + 32'h40, 32'h1234_5678);
      rd(BASE + 32'h40);
      wr(BASE + 32'h14, 32'hFFFF_FFFF);
      cyc(1, 2'b11, BASE + 32'h10, 32'h0000_0001, 0, 0);
      for (int i = 0; i < 8; i++) rd(BASE + 32'(i * 4));
      wr(BASE + 32'h10, 32'h0000_0201);
      idle(6);
      cyc(0, 2'b01, BASE, 0, 0, 0);
      for (int i = 0; i < 8; i++) rdk(BASE + 32'(i * 4), init_v[i]);
      for (int i = 0; i < 3000; i++) begin
         o = 3'($urandom_range(0, 7));
         a = BASE + {27'd0, o, 2'b00};
         if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 1) ? a + 32'h40 : a | 32'($urandom_range(1, 3));
         d = $urandom;
         case (o)
            3'd0: d = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 40));
            3'd1: d = 32'($urandom_range(0, 1));
            3'd2: d = m_time[31:0] + 32'($urandom_range(0, 20));
            3'd3: d = m_time[63:32] + 32'($urandom_range(0, 1));
            3'd4: d = ($urandom & 32'hFFFF_00FE) | {16'd0, 8'($urandom_range(0, 3)), 7'd0,
                      1'($urandom_range(0, 4) != 0)};
            default: ;
         endcase
         cyc(1'($urandom_range(0, 299) != 0), 2'($urandom_range(0, 3)), a, d, 0, 0);
      end
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/data_bus_timer.md
# data_bus_timer

Memory-mapped machine timer attached as a slave on the core's data bus, downstream of the data bus control unit. It decodes bus address and mode, holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a control register, and raises a level timer interrupt when the enabled counter reaches the compare value. Reads are answered combinationally in the access cycle and writes commit on the next rising clock edge, matching the bus's single-cycle, no-wait-state protocol.

## Interface
- `BASE_ADDR`, 32'h0000_2000: word-aligned base address of the 32-byte register window.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `data_bus_addr`  in  32  byte address from the bus master.
- `data_bus_mode`  in  2  2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 treated as idle.
- `data_bus_data`  inout  32  driven by this block only during a selected read, otherwise 32'bz; sampled as write data.
- `timer_irq`  out  1  registered level interrupt.

## Operation
- Select: `data_bus_addr[31:5] == BASE_ADDR[31:5]` and `data_bus_addr[1:0] == 2'b00`. Unaligned or out-of-window accesses are ignored: no drive, no write.
- Register map, offsets from `BASE_ADDR`:
  - 0x00 `MTIME_LO`, RW.
  - 0x04 `MTIME_HI`: read returns the shadow; write updates `mtime[63:32]`.
  - 0x08 `MTIMECMP_LO`, RW.
  - 0x0C `MTIMECMP_HI`, RW.
  - 0x10 `CTRL`, RW: bit0 = EN, bits[15:8] = PRE, all other bits read 0.
  - 0x14–0x1C: read 0, writes ignored.
- Read path is purely combinational: in a selected read cycle, `data_bus_data` carries the register value in the same cycle.
- HI shadow: a selected read of `MTIME_LO` latches the current `mtime[63:32]` into `hi_shadow` at the clock edge ending that cycle. Software reads LO then HI for a coherent 64-bit value.
- Prescaler: an 8-bit `pcnt` counts while EN=1.
  - When `pcnt == PRE`, `pcnt` returns to 0 and `mtime` increments by 1.
  - Net effect: one tick every PRE+1 cycles; PRE=0 ticks every cycle.
  - While EN=0, `pcnt` is held at 0 and `mtime` is frozen.
- `mtime` wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with full carry from the low to the high word. Comparison `mtime >= mtimecmp` is unsigned 64-bit.
- Interrupt: `timer_irq` is registered each cycle as `EN & (mtime >= mtimecmp)`, using current register values. It is level-sensitive; software clears it by raising `mtimecmp` or clearing EN.
- Simultaneous events:
  - A write to `MTIME_LO` or `MTIME_HI` in a tick cycle wins: the written word takes the bus value and no increment is applied to the 64-bit value that cycle. The unwritten word keeps its pre-write value, with no carry.
  - A write to `CTRL` resets `pcnt` to 0 in addition to loading EN/PRE.
- Reset values, applied when `reset_n` is low at a rising edge and overriding any bus access that cycle:
  - `mtime` = 0, `hi_shadow` = 0, `pcnt` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `CTRL` = 0.
  - `timer_irq` = 0.
  - `data_bus_data` = Z (no read is answered while reset is asserted).

## Timing
- Read latency 0: data is valid in the cycle `data_bus_mode`=01 is presented.
- Write latency 1: the new value is visible on a read in the following cycle.
- `timer_irq` rises 1 cycle after the edge at which `mtime` first equals `mtimecmp`. It falls 1 cycle after the edge at which the condition stops holding.
- After setting EN with PRE=p, the first increment of `mtime` occurs at the (p+1)-th rising edge after the write edge.
- Bus is never driven when not selected or when mode is not 01: no contention with other slaves.

## Test plan
- Reset, then read all offsets 0x00–0x1C → 0, 0, FFFF_FFFF, FFFF_FFFF, 0, 0, 0, 0; `timer_irq`=0; bus Z while idle.
- Write `CTRL`=0x0000_0301 (EN, PRE=3), run 20 cycles → `MTIME_LO` reads 5; increments observed exactly every 4 cycles.
- Write `MTIME_LO`=FFFF_FFFE, `MTIME_HI`=0, `CTRL`=1, wait 3 cycles → `MTIME_LO` then `MTIME_HI` reads show LO≈1, HI=1. Write HI in a later cycle → the shadow read still returns the value latched at the last LO read.
- `MTIMECMP`=10, `CTRL`=1 from `mtime`=0 → `timer_irq` asserts on the cycle after `mtime`=10. Write `MTIMECMP_LO`=100 → irq deasserts 1 cycle after the write edge. Clearing EN also drops irq.
- Accesses at BASE+0x02 (unaligned), BASE+0x40, and mode 2'b11 → no register change, bus stays Z.
- Assert `reset_n` low mid-count with irq high → next cycle all registers at reset values, irq=0.
